regread_arbiter: RTL and testbench

Round-robin arbiter that shares the register file's two 16-bit read ports (the 8-to-2 read multiplexer) among up to NREQ requesters (fetch/decode, ALU operand fetch, store-data, debug). Each cycle it grants up to two pending requests, drives the multiplexer selects with the granted register addresses, and captures the returned words into per-requester result registers. It sits between the requesters and the register file read multiplexer, in the operand-fetch stage.

---
 rtl/regread_arbiter_if.sv | 28 ++
 rtl/regread_arbiter.sv | 102 ++++++++++
 tb/tb_regread_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/regread_arbiter_if.sv
// Bundle between the operand-fetch requesters, the register-file read mux and
// the read-port arbiter. The arbiter takes the slave view.
interface regread_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 3
);
  logic                 stall;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ-1:0]      gnt;
  logic [AW-1:0]        sel0;
  logic [AW-1:0]        sel1;
  logic [DW-1:0]        q0;
  logic [DW-1:0]        q1;
  logic [NREQ*DW-1:0]   rdata;
  logic [NREQ-1:0]      rvalid;

  modport master (
    output stall, req, addr, q0, q1,
    input  gnt, sel0, sel1, rdata, rvalid
  );

  modport slave (
    input  stall, req, addr, q0, q1,
    output gnt, sel0, sel1, rdata, rvalid
  );
endinterface

// File: rtl/regread_arbiter.sv
// Round-robin sharing of the register file's two read ports among NREQ requesters:
// up to two grants per cycle, returned words captured into per-requester registers.
module regread_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  regread_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] rvalid_q;
  logic [DW-1:0]   rdata_q [NREQ];
  logic [AW-1:0]   addr_a  [NREQ];

  logic            arb_en;
  logic            w0_vld, w1_vld;
  logic [PW-1:0]   w0, w1;
  logic [NREQ-1:0] gnt_c;
  logic [AW-1:0]   sel0_c, sel1_c;

  for (genvar g = 0; g < NREQ; g++) begin : g_slices
    assign addr_a[g]                 = bus.addr[g*AW +: AW];
    assign bus.rdata[g*DW +: DW]     = rdata_q[g];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  assign arb_en = !rst && !bus.stall;

  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    // NOTE: every output of this block gets a default before any branch, so no latch can be inferred.
    w0_vld = 1'b0;
    w1_vld = 1'b0;
    w0     = '0;
    w1     = '0;
    gnt_c  = '0;
    sel0_c = '0;
    sel1_c = '0;
    ptr_d  = ptr_q;
    sum    = '0;
    idx    = '0;

    // Scan from the pointer, wrapping; the first two pending requesters win.
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      idx = sum[PW-1:0];
      if (arb_en && bus.req[idx]) begin
        if (!w0_vld) begin
          w0_vld = 1'b1;
          w0     = idx;
        end else if (!w1_vld) begin
          w1_vld = 1'b1;
          w1     = idx;
        end
      end
    end

    if (w0_vld) begin
      gnt_c[w0] = 1'b1;
      sel0_c    = addr_a[w0];
    end
    if (w1_vld) begin
      gnt_c[w1] = 1'b1;
      sel1_c    = addr_a[w1];
    end

    if (w1_vld)      ptr_d = ptr_inc(w1);
    else if (w0_vld) ptr_d = ptr_inc(w0);
  end

  assign bus.gnt    = gnt_c;
  assign bus.sel0   = sel0_c;
  assign bus.sel1   = sel1_c;
  assign bus.rvalid = rvalid_q;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      // NOTE: the result registers are reset too, since software may read zero back right after reset.
      for (int i = 0; i < NREQ; i++) rdata_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= gnt_c;
      if (w0_vld) rdata_q[w0] <= bus.q0;
      if (w1_vld) rdata_q[w1] <= bus.q1;
    end
  end

endmodule

// File: tb/tb_regread_arbiter.sv
// Scoreboarded bench for regread_arbiter: directed cases then random traffic
// against a queue-based round-robin reference model.
module tb_regread_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = 3;

  logic clk = 1'b0;
  logic rst;

  regread_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  regread_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register file behind the read mux.
  logic [DW-1:0] regs [8];
  assign bus.q0 = regs[bus.sel0];
  assign bus.q1 = regs[bus.sel1];

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [NREQ-1:0]    rvalid;
    logic [NREQ*DW-1:0] rdata;
  } exp_t;

  exp_t            exp_q [$];
  int              m_ptr;
  logic [DW-1:0]   m_rdata [NREQ];
  logic [NREQ-1:0] last_gnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ*AW-1:0] mk_addr(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  // One arbitration cycle: drive, check combinational outputs, advance model, queue registered result.
  task automatic cycle(input bit r, input bit s, input logic [NREQ-1:0] rq,
                       input logic [NREQ*AW-1:0] ad, input bit scramble);
    int              win [$];
    logic [NREQ-1:0] eg;
    logic [AW-1:0]   es0, es1;
    exp_t            e;
    @(posedge clk);
    #1;
    if (scramble) regs[$urandom_range(0, 7)] = DW'($urandom);
    rst       = r;
    bus.stall = s;
    bus.req   = rq;
    bus.addr  = ad;

    eg  = '0;
    es0 = '0;
    es1 = '0;
    if (!r && !s) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (rq[i] && win.size() < 2) win.push_back(i);
      end
    end
    foreach (win[j]) eg[win[j]] = 1'b1;
    if (win.size() > 0) es0 = ad[win[0]*AW +: AW];
    if (win.size() > 1) es1 = ad[win[1]*AW +: AW];

    #3;
    last_gnt = bus.gnt;
    check("gnt",  bus.gnt,  eg);
    check("sel0", bus.sel0, es0);
    check("sel1", bus.sel1, es1);

    if (r) begin
      m_ptr = 0;
      foreach (m_rdata[i]) m_rdata[i] = '0;
      e.rvalid = '0;
    end else begin
      if (win.size() > 0) m_rdata[win[0]] = regs[es0];
      if (win.size() > 1) m_rdata[win[1]] = regs[es1];
      if (win.size() > 0) m_ptr = (win[$] + 1) % NREQ;
      e.rvalid = eg;
    end
    for (int i = 0; i < NREQ; i++) e.rdata[i*DW +: DW] = m_rdata[i];
    exp_q.push_back(e);
  endtask

  // Monitor: after each edge, compare registered outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rvalid", bus.rvalid, e.rvalid);
        check("rdata",  bus.rdata,  e.rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.stall = 1'b0;
    bus.req   = '0;
    bus.addr  = '0;
    m_ptr     = 0;
    foreach (m_rdata[i]) m_rdata[i] = '0;
    for (int i = 0; i < 8; i++) regs[i] = DW'(16'h1000 + i);
    regs[5] = 16'hAAAA;
    regs[2] = 16'h5555;
    regs[7] = 16'h1234;

    // Reset held two cycles with all requesting.
    cycle(1, 0, 4'b1111, mk_addr(1, 2, 3, 4), 0);
    check("rst_gnt", last_gnt, 4'b0000);
    cycle(1, 0, 4'b1111, mk_addr(1, 2, 3, 4), 0);
    check("rst_gnt2",   last_gnt,   4'b0000);
    check("rst_rvalid", bus.rvalid, 4'b0000);
    check("rst_rdata",  bus.rdata,  64'h0);

    // Release, then round-robin fairness.
    cycle(0, 0, 4'b1111, mk_addr(1, 2, 3, 4), 0);
    check("rr_gnt0", last_gnt, 4'b0011);
    cycle(0, 0, 4'b1111, mk_addr(1, 2, 3, 4), 0);
    check("rr_gnt1", last_gnt, 4'b1100);
    cycle(0, 0, 4'b1111, mk_addr(1, 2, 3, 4), 0);
    check("rr_gnt2", last_gnt, 4'b0011);
    cycle(0, 0, 4'b1111, mk_addr(1, 2, 3, 4), 0);
    check("rr_gnt3", last_gnt, 4'b1100);

    // Two-way grant from ptr=0.
    cycle(0, 0, 4'b0101, mk_addr(5, 0, 2, 0), 0);
    check("two_gnt",  last_gnt, 4'b0101);
    check("two_sel0", bus.sel0, 3'd5);
    check("two_sel1", bus.sel1, 3'd2);

    // Wrap-around from ptr=3.
    cycle(0, 0, 4'b1001, mk_addr(1, 0, 0, 4), 0);
    check("wrap_gnt",    last_gnt,            4'b1001);
    check("two_rvalid",  bus.rvalid,          4'b0101);
    check("two_rdata0",  bus.rdata[0*DW +: DW], 16'hAAAA);
    check("two_rdata2",  bus.rdata[2*DW +: DW], 16'h5555);

    // Single request, then stall.
    cycle(0, 0, 4'b0010, mk_addr(0, 7, 0, 0), 0);
    check("single_gnt",  last_gnt, 4'b0010);
    check("single_sel0", bus.sel0, 3'd7);
    check("single_sel1", bus.sel1, 3'd0);
    cycle(0, 1, 4'b0010, mk_addr(0, 7, 0, 0), 0);
    check("stall_gnt", last_gnt, 4'b0000);
    cycle(0, 0, 4'b0000, mk_addr(0, 0, 0, 0), 0);
    check("stall_rvalid", bus.rvalid,            4'b0000);
    check("stall_rdata1", bus.rdata[1*DW +: DW], 16'h1234);

    // Reset mid-operation.
    cycle(1, 0, 4'b0011, mk_addr(1, 2, 0, 0), 0);
    check("midrst_gnt", last_gnt, 4'b0000);
    cycle(0, 0, 4'b1111, mk_addr(3, 4, 5, 6), 0);
    check("midrst_rvalid", bus.rvalid, 4'b0000);
    check("midrst_rdata",  bus.rdata,  64'h0);
    check("midrst_ptr0",   last_gnt,   4'b0011);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      cycle(($urandom % 50) == 0, ($urandom % 8) == 0, NREQ'($urandom),
            (NREQ*AW)'($urandom), 1);
    end

    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
